iomem_arbiter: RTL

//  Two-master arbiter for the shared iomem valid/ready bus, which serves main RAM (multi-cycle

---
 rtl/iomem_arbiter.sv | 87 ++++++++
 1 files changed

// File: rtl/iomem_arbiter.sv
// iomem_arbiter: round-robin two-master arbiter for the shared iomem valid/ready bus.
// The granted request is latched and replayed downstream; a watchdog aborts a stuck access.
module iomem_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                m0_valid_i,
  input  logic [DATA_W/8-1:0] m0_wstrb_i,
  input  logic [ADDR_W-1:0]   m0_addr_i,
  input  logic [DATA_W-1:0]   m0_wdata_i,
  output logic                m0_ready_o,
  output logic [DATA_W-1:0]   m0_rdata_o,
  output logic                m0_err_o,
  input  logic                m1_valid_i,
  input  logic [DATA_W/8-1:0] m1_wstrb_i,
  input  logic [ADDR_W-1:0]   m1_addr_i,
  input  logic [DATA_W-1:0]   m1_wdata_i,
  output logic                m1_ready_o,
  output logic [DATA_W-1:0]   m1_rdata_o,
  output logic                m1_err_o,
  output logic                iomem_valid_o,
  output logic [DATA_W/8-1:0] iomem_wstrb_o,
  output logic [ADDR_W-1:0]   iomem_addr_o,
  output logic [DATA_W-1:0]   iomem_wdata_o,
  input  logic                iomem_ready_i,
  input  logic [DATA_W-1:0]   iomem_rdata_i
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, next_state;
  logic last_grant, grant, grant_next, tie, take, expire, finish;
  logic [CNT_W-1:0] cnt;
  logic [DATA_W/8-1:0] wstrb;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  // only a tie moves the round-robin pointer; a lone requester wins outright
  assign tie = m0_valid_i & m1_valid_i;
  assign grant_next = tie ? ~last_grant : ~m0_valid_i;
  assign take = state == IDLE && (m0_valid_i || m1_valid_i);
  assign expire = cnt == CNT_W'(TIMEOUT_CYCLES - 1);
  assign finish = state == BUSY && (iomem_ready_i || expire);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else state <= next_state;
  end
  always_comb begin
    next_state = state == IDLE ? (take ? BUSY : IDLE) :
                 state == BUSY ? (finish ? DONE : BUSY) : IDLE;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_grant <= 1'b1;
      grant      <= 1'b0;
      cnt        <= '0;
      wstrb      <= '0;
      addr       <= '0;
      wdata      <= '0;
    end else if (take) begin
      grant      <= grant_next;
      last_grant <= tie ? grant_next : last_grant;
      cnt        <= '0;
      wstrb      <= grant_next ? m1_wstrb_i : m0_wstrb_i;
      addr       <= grant_next ? m1_addr_i : m0_addr_i;
      wdata      <= grant_next ? m1_wdata_i : m0_wdata_i;
    end else if (state == BUSY && !finish) begin
      cnt <= cnt + 1'b1;
    end
  end
  always_comb begin
    iomem_valid_o = state == BUSY;
    iomem_wstrb_o = wstrb;
    iomem_addr_o  = addr;
    iomem_wdata_o = wdata;
    m0_ready_o    = finish && !grant;
    m1_ready_o    = finish && grant;
    m0_err_o      = m0_ready_o && !iomem_ready_i;
    m1_err_o      = m1_ready_o && !iomem_ready_i;
    m0_rdata_o    = m0_ready_o && iomem_ready_i ? iomem_rdata_i : '0;
    m1_rdata_o    = m1_ready_o && iomem_ready_i ? iomem_rdata_i : '0;
  end
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(m0_ready_o && m1_ready_o));
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    state == BUSY && !finish |=> $stable({iomem_wstrb_o, iomem_addr_o, iomem_wdata_o}));
endmodule
